// File: rtl/bk_adder_arbiter.sv
// Round-robin sequencer that time-shares one combinational Brent-Kung adder among N_REQ clients,
// plus the 8-bit Brent-Kung adder it is meant to drive.

module bk_adder8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] sum,
   output logic       cout
);
   logic [7:0] g, p;
   logic g10, g32, p32, g54, p54, g76, p76;
   logic g30, g74, p74, g70, g20, g40, g50, g60;

   assign g = a & b;
   assign p = a ^ b;

   // Up-sweep: pairwise groups, then nibbles, then the full byte
   assign g10 = g[1] | (p[1] & g[0]);
   assign g32 = g[3] | (p[3] & g[2]);
   assign p32 = p[3] & p[2];
   assign g54 = g[5] | (p[5] & g[4]);
   assign p54 = p[5] & p[4];
   assign g76 = g[7] | (p[7] & g[6]);
   assign p76 = p[7] & p[6];
   assign g30 = g32 | (p32 & g10);
   assign g74 = g76 | (p76 & g54);
   assign p74 = p76 & p54;
   assign g70 = g74 | (p74 & g30);

   // Down-sweep fills in the prefixes the tree skipped
   assign g50 = g54 | (p54 & g30);
   assign g20 = g[2] | (p[2] & g10);
   assign g40 = g[4] | (p[4] & g30);
   assign g60 = g[6] | (p[6] & g50);

   assign sum  = p ^ {g60, g50, g40, g30, g20, g10, g[0], 1'b0};
   assign cout = g70;
endmodule

module bk_adder_arbiter #(
   parameter int N_REQ = 2,
   parameter int W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] a_flat,
   input  logic [N_REQ*W-1:0] b_flat,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [W-1:0]       result,
   output logic               carry,
   output logic               busy,
   output logic [W-1:0]       add_a,
   output logic [W-1:0]       add_b,
   input  logic [W-1:0]       add_sum
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t        state, next_state;
   logic [PW-1:0] rr_ptr, tag, winner;
   logic          found, do_grant;

   // Round-robin search starting after the last winner; the requester being
   // captured is skipped so it cannot win twice in a row on a stale request.
   always_comb begin
      int cand;
      cand   = 0;
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(rr_ptr) + k) % N_REQ;
         if (!found && req[cand] && !(state == CAPTURE && cand == int'(tag))) begin
            found  = 1'b1;
            winner = PW'(cand);
         end
      end
   end

   always_comb begin
      next_state = state;
      do_grant   = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               do_grant   = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE: next_state = CAPTURE;
         CAPTURE: begin
            if (found) begin
               do_grant   = 1'b1;
               next_state = ISSUE;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Datapath: operands launched on grant, sum and wrap-detect captured one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt    <= '0;
         done   <= '0;
         result <= '0;
         carry  <= 1'b0;
         add_a  <= '0;
         add_b  <= '0;
         tag    <= '0;
         rr_ptr <= PW'(N_REQ - 1);
      end else begin
         gnt  <= '0;
         done <= '0;
         if (state == CAPTURE) begin
            result    <= add_sum;
            carry     <= (add_sum < add_a);
            done[tag] <= 1'b1;
         end
         if (do_grant) begin
            gnt[winner] <= 1'b1;
            add_a       <= a_flat[winner*W +: W];
            add_b       <= b_flat[winner*W +: W];
            tag         <= winner;
            rr_ptr      <= winner;
         end
      end
   end

   assign busy = (state != IDLE);
endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Self-checking bench for bk_adder_arbiter driving the shared bk_adder8 with two requesters.

module tb_bk_adder_arbiter;
   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [15:0] a_flat, b_flat;
   logic [1:0]  gnt, done;
   logic [7:0]  result, add_a, add_b, add_sum;
   logic        carry, busy, add_cout;

   int checks;
   int errors;
   int lastWin;

   typedef struct {
      logic [1:0] r;
      logic [7:0] a0, b0, a1, b1;
      int         win;
      logic [7:0] sum;
      logic       cy;
   } vec_t;

   vec_t vecs[7];

   bk_adder_arbiter #(.N_REQ(2), .W(8)) dut (
      .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
      .gnt(gnt), .done(done), .result(result), .carry(carry), .busy(busy),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
   );

   bk_adder8 adder (.a(add_a), .b(add_b), .sum(add_sum), .cout(add_cout));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One complete transaction from IDLE: grant, capture, done pulse
   task automatic applyStimulus(input logic [1:0] r, input logic [7:0] a0, b0, a1, b1,
                                input int win, input logic [7:0] sum, input logic cy);
      @(negedge clk);
      req    = r;
      a_flat = {a1, a0};
      b_flat = {b1, b0};
      @(posedge clk); #1;
      checkOutput("gnt", 16'(gnt), 16'(2'b01 << win));
      checkOutput("busy_issue", 16'(busy), 16'd1);
      @(negedge clk);
      req    = 2'b00;
      a_flat = 16'($urandom);
      b_flat = 16'($urandom);
      @(posedge clk); #1;
      checkOutput("done_early", 16'(done), 16'd0);
      @(posedge clk); #1;
      checkOutput("done", 16'(done), 16'(2'b01 << win));
      checkOutput("result", 16'(result), 16'(sum));
      checkOutput("carry", 16'(carry), 16'(cy));
      checkOutput("adder_cout", 16'(add_cout), 16'(cy));
      checkOutput("busy_idle", 16'(busy), 16'd0);
      lastWin = win;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      lastWin = 1;
      rst     = 1'b1;
      req     = 2'b11;
      a_flat  = 16'h1234;
      b_flat  = 16'h5678;

      vecs[0] = '{2'b01, 8'h0E, 8'h07, 8'h00, 8'h00, 0, 8'h15, 1'b0};
      vecs[1] = '{2'b10, 8'h00, 8'h00, 8'hFF, 8'h01, 1, 8'h00, 1'b1};
      vecs[2] = '{2'b10, 8'h00, 8'h00, 8'h10, 8'h10, 1, 8'h20, 1'b0};
      vecs[3] = '{2'b11, 8'h80, 8'h80, 8'h7F, 8'h80, 0, 8'h00, 1'b1};
      vecs[4] = '{2'b11, 8'h80, 8'h80, 8'h7F, 8'h80, 1, 8'hFF, 1'b0};
      vecs[5] = '{2'b01, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 8'hFE, 1'b1};
      vecs[6] = '{2'b10, 8'h00, 8'h00, 8'h01, 8'h02, 1, 8'h03, 1'b0};

      // Reset held with all requests high
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         checkOutput("rst_gnt", 16'(gnt), 16'd0);
         checkOutput("rst_done", 16'(done), 16'd0);
         checkOutput("rst_result", 16'(result), 16'd0);
         checkOutput("rst_busy", 16'(busy), 16'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      req = 2'b00;

      for (int i = 0; i < 7; i++)
         applyStimulus(vecs[i].r, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                       vecs[i].win, vecs[i].sum, vecs[i].cy);

      // Back-to-back round robin with both requests held
      @(negedge clk);
      req    = 2'b11;
      a_flat = {8'h00, 8'h01};
      b_flat = {8'h01, 8'h04};
      @(posedge clk); #1;
      checkOutput("rr_gnt_first", 16'(gnt), 16'b01);
      for (int t = 1; t <= 4; t++) begin
         if (t == 4) begin
            @(negedge clk);
            req = 2'b00;
         end
         @(posedge clk);
         @(posedge clk); #1;
         checkOutput("rr_done", 16'(done), 16'(2'b01 << ((t - 1) % 2)));
         checkOutput("rr_result", 16'(result), ((t - 1) % 2 == 0) ? 16'h05 : 16'h01);
         checkOutput("rr_gnt", 16'(gnt), (t < 4) ? 16'(2'b01 << (t % 2)) : 16'd0);
      end
      @(posedge clk); #1;
      checkOutput("rr_busy_end", 16'(busy), 16'd0);

      // Reset while the grant is in ISSUE
      @(negedge clk);
      req    = 2'b01;
      a_flat = {8'h00, 8'h22};
      b_flat = {8'h00, 8'h33};
      @(posedge clk); #1;
      checkOutput("mid_gnt", 16'(gnt), 16'b01);
      @(negedge clk);
      req = 2'b00;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("mid_done", 16'(done), 16'd0);
      checkOutput("mid_busy", 16'(busy), 16'd0);
      checkOutput("mid_result", 16'(result), 16'd0);
      checkOutput("mid_add_a", 16'(add_a), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      lastWin = 1;
      @(posedge clk); #1;
      checkOutput("mid_done_after", 16'(done), 16'd0);
      applyStimulus(2'b01, 8'h04, 8'h03, 8'h00, 8'h00, 0, 8'h07, 1'b0);

      // Random traffic against a reference sum and round-robin pointer
      for (int n = 0; n < 1000; n++) begin
         logic [1:0] r;
         logic [7:0] a0, b0, a1, b1;
         logic [8:0] full;
         int         w;
         r  = 2'($urandom_range(1, 3));
         a0 = 8'($urandom);
         b0 = 8'($urandom);
         a1 = 8'($urandom);
         b1 = 8'($urandom);
         w  = (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : (lastWin + 1) % 2;
         full = (w == 0) ? ({1'b0, a0} + {1'b0, b0}) : ({1'b0, a1} + {1'b0, b1});
         applyStimulus(r, a0, b0, a1, b1, w, full[7:0], full[8]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
